// File: rtl/secded_pkg.sv
// Shared sizing helpers and error classification for the SECDED stream codec.
package secded_pkg;

    typedef enum logic [1:0] {
        CLEAN  = 2'd0,
        SINGLE = 2'd1,
        PARITY = 2'd2,
        DOUBLE = 2'd3
    } err_class_e;

    // Smallest R such that 2^R covers every Hamming position plus the zero syndrome.
    function automatic int check_bits(input int data_w);
        int r;
        r = 1;
        while ((1 << r) < data_w + r + 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int cw_width(input int data_w);
        return data_w + check_bits(data_w) + 1;
    endfunction

    function automatic logic is_pow2(input int pos);
        return (pos != 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Payload bit index carried at a non-power-of-two Hamming position.
    function automatic int data_idx(input int pos);
        int n;
        n = 0;
        for (int b = 0; b < 31; b++) begin
            if ((1 << b) <= pos) begin
                n++;
            end
        end
        return pos - 1 - n;
    endfunction

endpackage

// File: rtl/secded_stream_codec_if.sv
// Stream, fault-injection and statistics signals of the SECDED codec in one bundle.
interface secded_stream_codec_if
    import secded_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) ();
    localparam int R    = check_bits(DATA_W);
    localparam int CW_W = cw_width(DATA_W);

    logic              i_valid;
    logic              i_ready;
    logic [DATA_W-1:0] i_data;
    logic [CW_W-1:0]   i_flip_mask;
    logic              o_valid;
    logic              o_ready;
    logic [DATA_W-1:0] o_data;
    logic              o_single_err;
    logic              o_parity_err;
    logic              o_double_err;
    logic [R-1:0]      o_err_pos;
    logic              i_cnt_clr;
    logic [CNT_W-1:0]  o_cnt_corr;
    logic [CNT_W-1:0]  o_cnt_uncorr;

    modport slave (
        input  i_valid, i_data, i_flip_mask, o_ready, i_cnt_clr,
        output i_ready, o_valid, o_data, o_single_err, o_parity_err,
               o_double_err, o_err_pos, o_cnt_corr, o_cnt_uncorr
    );

    modport master (
        output i_valid, i_data, i_flip_mask, o_ready, i_cnt_clr,
        input  i_ready, o_valid, o_data, o_single_err, o_parity_err,
               o_double_err, o_err_pos, o_cnt_corr, o_cnt_uncorr
    );

endinterface

// File: rtl/secded_dec_core.sv
// Combinational syndrome, classification and single-bit correction of one codeword.
module secded_dec_core
    import secded_pkg::*;
#(
    parameter  int DATA_W = 8,
    localparam int R      = check_bits(DATA_W),
    localparam int CW_W   = cw_width(DATA_W)
) (
    input  logic [CW_W-1:0]   cw,
    output logic [DATA_W-1:0] data,
    output err_class_e        err_class,
    output logic [R-1:0]      syndrome
);

    logic [R-1:0]    syn;
    logic            overall;
    logic [CW_W-1:0] fixed;

    always_comb begin
        syn = '0;
        for (int p = 1; p < CW_W; p++) begin
            if (cw[p]) begin
                syn = syn ^ R'(p);
            end
        end
        overall = ^cw;

        // A syndrome beyond the last position cannot be a single flip.
        err_class = CLEAN;
        if (syn == '0) begin
            err_class = overall ? PARITY : CLEAN;
        end else if (!overall || (int'(syn) > CW_W - 1)) begin
            err_class = DOUBLE;
        end else begin
            err_class = SINGLE;
        end

        fixed = cw;
        for (int p = 1; p < CW_W; p++) begin
            if ((err_class == SINGLE) && (syn == R'(p))) begin
                fixed[p] = ~cw[p];
            end
        end

        data = '0;
        for (int p = 1; p < CW_W; p++) begin
            if (!is_pow2(p)) begin
                data[data_idx(p)] = fixed[p];
            end
        end

        syndrome = syn;
    end

endmodule

// File: rtl/secded_stream_codec.sv
// Two-stage SECDED encode/inject/decode pipeline with valid/ready flow and saturating error counters.
module secded_stream_codec
    import secded_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input logic                  clk,
    input logic                  rst,
    secded_stream_codec_if.slave bus
);

    localparam int R    = check_bits(DATA_W);
    localparam int CW_W = cw_width(DATA_W);

    logic              s1_valid_q, s1_valid_d;
    logic [CW_W-1:0]   s1_cw_q, s1_cw_d;
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    err_class_e        s2_class_q, s2_class_d;
    logic [R-1:0]      s2_pos_q, s2_pos_d;
    logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d;
    logic [CNT_W-1:0]  cnt_uncorr_q, cnt_uncorr_d;

    logic [CW_W-1:0]   enc_cw;
    logic              par;
    logic              s1_load, s2_load, in_fire, out_fire;
    logic [DATA_W-1:0] dec_data;
    err_class_e        dec_class;
    logic [R-1:0]      dec_syn;

    // Check bits are still zero while their own parity is accumulated.
    always_comb begin
        enc_cw = '0;
        par    = 1'b0;
        for (int p = 1; p < CW_W; p++) begin
            if (!is_pow2(p)) begin
                enc_cw[p] = bus.i_data[data_idx(p)];
            end
        end
        for (int i = 0; i < R; i++) begin
            par = 1'b0;
            for (int p = 1; p < CW_W; p++) begin
                if (((p >> i) & 1) != 0) begin
                    par = par ^ enc_cw[p];
                end
            end
            enc_cw[1 << i] = par;
        end
        enc_cw[0] = ^enc_cw[CW_W-1:1];
    end

    secded_dec_core #(.DATA_W(DATA_W)) u_dec (
        .cw        (s1_cw_q),
        .data      (dec_data),
        .err_class (dec_class),
        .syndrome  (dec_syn)
    );

    always_comb begin
        s2_load  = !s2_valid_q || bus.o_ready;
        s1_load  = !s1_valid_q || s2_load;
        in_fire  = bus.i_valid && s1_load;
        out_fire = s2_valid_q && bus.o_ready;

        s1_valid_d = s1_load ? bus.i_valid : s1_valid_q;
        s1_cw_d    = in_fire ? (enc_cw ^ bus.i_flip_mask) : s1_cw_q;

        // Output registers only change when a new word enters stage 2, keeping them stable under stall.
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_class_d = s2_class_q;
        s2_pos_d   = s2_pos_q;
        if (s2_load && s1_valid_q) begin
            s2_data_d  = dec_data;
            s2_class_d = dec_class;
            s2_pos_d   = dec_syn;
        end

        cnt_corr_d   = cnt_corr_q;
        cnt_uncorr_d = cnt_uncorr_q;
        if (bus.i_cnt_clr) begin
            cnt_corr_d   = '0;
            cnt_uncorr_d = '0;
        end else if (out_fire) begin
            if (((s2_class_q == SINGLE) || (s2_class_q == PARITY)) && (cnt_corr_q != '1)) begin
                cnt_corr_d = cnt_corr_q + 1'b1;
            end
            if ((s2_class_q == DOUBLE) && (cnt_uncorr_q != '1)) begin
                cnt_uncorr_d = cnt_uncorr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_cw_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_class_q   <= CLEAN;
            s2_pos_q     <= '0;
            cnt_corr_q   <= '0;
            cnt_uncorr_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_cw_q      <= s1_cw_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_class_q   <= s2_class_d;
            s2_pos_q     <= s2_pos_d;
            cnt_corr_q   <= cnt_corr_d;
            cnt_uncorr_q <= cnt_uncorr_d;
        end
    end

    assign bus.i_ready      = s1_load;
    assign bus.o_valid      = s2_valid_q;
    assign bus.o_data       = s2_data_q;
    assign bus.o_single_err = (s2_class_q == SINGLE);
    assign bus.o_parity_err = (s2_class_q == PARITY);
    assign bus.o_double_err = (s2_class_q == DOUBLE);
    assign bus.o_err_pos    = s2_pos_q;
    assign bus.o_cnt_corr   = cnt_corr_q;
    assign bus.o_cnt_uncorr = cnt_uncorr_q;

endmodule

// File: tb/tb_secded_stream_codec.sv
// Directed bench for secded_stream_codec: vector table, backpressure, reset flush and counter saturation/clear.
module tb_secded_stream_codec;

    typedef struct {
        logic [7:0]  data;
        logic [12:0] mask;
        logic [7:0]  exp_data;
        logic        exp_single;
        logic        exp_parity;
        logic        exp_double;
        logic [3:0]  exp_pos;
    } vec_t;

    localparam int NVEC = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    secded_stream_codec_if #(.DATA_W(8), .CNT_W(16)) bus ();
    secded_stream_codec_if #(.DATA_W(8), .CNT_W(2))  bus2 ();

    secded_stream_codec #(.DATA_W(8), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    secded_stream_codec #(.DATA_W(8), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Offers one word on the 16-bit-counter instance and waits (bounded) for it at the output.
    task automatic applyStimulus(input vec_t v, output int lat);
        @(negedge clk);
        bus.i_valid     = 1'b1;
        bus.i_data      = v.data;
        bus.i_flip_mask = v.mask;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        lat = 1;
        while (!bus.o_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t       vecs[NVEC];
        int         lat;
        int         exp_corr;
        int         exp_uncorr;
        int         n;
        logic       seen;
        logic [7:0] got[4];

        // Data bits 0..7 live at Hamming positions 3,5,6,7,9,10,11,12.
        vecs[0]  = '{8'hA5, 13'h0000, 8'hA5, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{8'hA5, 13'h0008, 8'hA5, 1'b1, 1'b0, 1'b0, 4'd3};
        vecs[2]  = '{8'hA5, 13'h0028, 8'hA6, 1'b0, 1'b0, 1'b1, 4'd6};
        vecs[3]  = '{8'h3C, 13'h0001, 8'h3C, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[4]  = '{8'h00, 13'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[5]  = '{8'hFF, 13'h0000, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[6]  = '{8'h5A, 13'h1000, 8'h5A, 1'b1, 1'b0, 1'b0, 4'd12};
        vecs[7]  = '{8'h5A, 13'h0100, 8'h5A, 1'b1, 1'b0, 1'b0, 4'd8};
        vecs[8]  = '{8'h5A, 13'h0002, 8'h5A, 1'b1, 1'b0, 1'b0, 4'd1};
        vecs[9]  = '{8'hA5, 13'h0009, 8'hA4, 1'b0, 1'b0, 1'b1, 4'd3};
        vecs[10] = '{8'h96, 13'h0112, 8'h96, 1'b0, 1'b0, 1'b1, 4'd13};
        vecs[11] = '{8'h96, 13'h1006, 8'h16, 1'b0, 1'b0, 1'b1, 4'd15};
        vecs[12] = '{8'hC3, 13'h0400, 8'hC3, 1'b1, 1'b0, 1'b0, 4'd10};

        bus.i_valid      = 1'b0;
        bus.i_data       = '0;
        bus.i_flip_mask  = '0;
        bus.o_ready      = 1'b1;
        bus.i_cnt_clr    = 1'b0;
        bus2.i_valid     = 1'b0;
        bus2.i_data      = '0;
        bus2.i_flip_mask = '0;
        bus2.o_ready     = 1'b1;
        bus2.i_cnt_clr   = 1'b0;
        exp_corr   = 0;
        exp_uncorr = 0;
        for (int k = 0; k < 4; k++) got[k] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_handshake", {bus.i_ready, bus.o_valid}, 2'b10);
        checkOutput("reset_outputs",
                    {bus.o_data, bus.o_single_err, bus.o_parity_err, bus.o_double_err, bus.o_err_pos}, 0);
        checkOutput("reset_counters", {bus.o_cnt_corr, bus.o_cnt_uncorr}, 0);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], lat);
            checkOutput($sformatf("vec%0d_latency", i), lat, 2);
            checkOutput($sformatf("vec%0d_result", i),
                        {bus.o_data, bus.o_single_err, bus.o_parity_err, bus.o_double_err, bus.o_err_pos},
                        {vecs[i].exp_data, vecs[i].exp_single, vecs[i].exp_parity,
                         vecs[i].exp_double, vecs[i].exp_pos});
            if (vecs[i].exp_single || vecs[i].exp_parity) exp_corr++;
            if (vecs[i].exp_double) exp_uncorr++;
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_cnt_corr", i), bus.o_cnt_corr, exp_corr);
            checkOutput($sformatf("vec%0d_cnt_uncorr", i), bus.o_cnt_uncorr, exp_uncorr);
        end

        // Backpressure: three clean words while the sink stalls.
        @(negedge clk);
        bus.o_ready     = 1'b0;
        bus.i_valid     = 1'b1;
        bus.i_data      = 8'h11;
        bus.i_flip_mask = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("bp_ready_second", bus.i_ready, 1);
        bus.i_data = 8'h22;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.i_data = 8'h33;
        checkOutput("bp_ready_full", bus.i_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_hold", {bus.o_valid, bus.i_ready, bus.o_data, bus.o_single_err}, {1'b1, 1'b0, 8'h11, 1'b0});
        @(negedge clk);
        bus.o_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.o_valid && n < 4) begin
                got[n] = bus.o_data;
                n++;
            end
            @(posedge clk);
            #1;
            if (k == 0) bus.i_valid = 1'b0;
        end
        checkOutput("bp_count", n, 3);
        checkOutput("bp_order", {got[0], got[1], got[2]}, {8'h11, 8'h22, 8'h33});
        checkOutput("bp_counters_unchanged", {bus.o_cnt_corr, bus.o_cnt_uncorr}, {16'(exp_corr), 16'(exp_uncorr)});

        // Reset while a corrupted word is in flight.
        @(negedge clk);
        bus.i_valid     = 1'b1;
        bus.i_data      = 8'h5A;
        bus.i_flip_mask = 13'h0008;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("flush_state", {bus.o_valid, bus.o_single_err, bus.o_err_pos, bus.o_cnt_corr}, 0);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.o_valid) seen = 1'b1;
        end
        checkOutput("flush_no_output", seen, 0);
        checkOutput("flush_not_counted", {bus.o_cnt_corr, bus.o_cnt_uncorr}, 0);

        // 2-bit counters: five single-error words must stop at 3.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus2.i_valid     = 1'b1;
            bus2.i_data      = 8'(k + 1);
            bus2.i_flip_mask = 13'h0010;
        end
        @(negedge clk);
        bus2.i_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("sat_cnt_corr", bus2.o_cnt_corr, 3);
        checkOutput("sat_cnt_uncorr", bus2.o_cnt_uncorr, 0);

        // Clear coinciding with an output handshake wins.
        @(negedge clk);
        bus2.i_valid = 1'b1;
        bus2.i_data  = 8'h42;
        @(posedge clk);
        #1;
        bus2.i_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("clr_word_ready", {bus2.o_valid, bus2.o_single_err, bus2.o_data, bus2.o_err_pos},
                    {1'b1, 1'b1, 8'h42, 4'd4});
        @(negedge clk);
        bus2.i_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        bus2.i_cnt_clr = 1'b0;
        checkOutput("clr_priority", {bus2.o_valid, bus2.o_cnt_corr}, 0);

        @(negedge clk);
        bus2.i_valid = 1'b1;
        bus2.i_data  = 8'h07;
        @(posedge clk);
        #1;
        bus2.i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("clr_then_count", bus2.o_cnt_corr, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/secded_stream_codec.md
# secded_stream_codec

Parametrised, pipelined SECDED (extended Hamming) codec for streaming data. It encodes a DATA_W-bit word and XORs a per-word fault-injection mask onto the codeword. It then decodes, corrects and classifies the word, and keeps saturating error statistics. This is the next-generation replacement for the fixed 4-bit combinational encoder/noise/decoder chain. It adds width generality, valid/ready flow control with backpressure, error-position reporting and counters.

## Interface
- DATA_W, 8: payload width, 4..64
- CNT_W, 16: width of each statistics counter, ≥2
- R (derived, not overridable): smallest R with 2^R ≥ DATA_W+R+1
- CW_W (derived): DATA_W+R+1, codeword width including overall parity

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  input word present
- i_ready  out  1  codec accepts input this cycle
- i_data  in  DATA_W  payload
- i_flip_mask  in  CW_W  bits to invert in the codeword (bit 0 = overall parity, bit k = Hamming position k)
- o_valid  out  1  output word present
- o_ready  in  1  downstream accepts
- o_data  out  DATA_W  corrected payload
- o_single_err  out  1  one error in positions 1..CW_W-1, corrected
- o_parity_err  out  1  only the overall parity bit flipped; payload intact
- o_double_err  out  1  uncorrectable; o_data is uncorrected raw payload
- o_err_pos  out  R  syndrome (0 when clean or parity-only)
- i_cnt_clr  in  1  clear both counters
- o_cnt_corr  out  CNT_W  words with single or parity error
- o_cnt_uncorr  out  CNT_W  words with double error

## Operation
- Codeword layout: Hamming positions 1..CW_W-1. Check bits sit at power-of-two positions. Data bits fill the remaining positions in ascending order, LSB first. Position 0 holds even parity over positions 1..CW_W-1.
- Stage 1 (S1) registers: encode(i_data) XOR i_flip_mask.
- Stage 2 (S2) registers the decoded result. Syndrome S = XOR of indices of set bits. P = XOR of all CW_W bits.
- Classification:
  - S=0, P=0: clean.
  - S=0, P=1: parity_err.
  - S≠0, P=1, S≤CW_W-1: single. Invert bit S before extracting data.
  - S≠0, P=0: double.
  - S>CW_W-1: double.
- Exactly one or none of the three flags is high while o_valid=1.
- Counters increment only on output handshake (o_valid&o_ready) and saturate at all-ones.
- i_cnt_clr has priority over an increment in the same cycle.

## Timing
- Latency: 2 cycles from input handshake to o_valid with no stall. Throughput is 1 word/cycle.
- Each stage holds a valid bit. A stage loads when it is empty or its content moves on this cycle.
- i_ready = !s1_valid | !s2_valid | o_ready. This is combinational from o_ready; no other comb path from input to output.
- While o_valid=1 and o_ready=0, o_data, the flags and o_err_pos stay stable.
- Reset values: o_valid=0, all flags 0, o_data=0, o_err_pos=0, counters 0. i_ready=1 after reset.
- Reset mid-stream flushes both stages. In-flight words are lost and not counted.
- Input presented with i_ready=0 is ignored. The source must hold it.

## Structure
- Package secded_pkg holds the check-bit-count function, the CW_W function, the position-is-power-of-two function, and the error-class enum (CLEAN, SINGLE, PARITY, DOUBLE).
- Sub-module secded_dec_core: combinational syndrome, classification and correction for one codeword. Instantiated once in S2. The encoder stays inline.
- The top level holds the pipeline registers, the handshake logic and the counters.

## Test plan
- DATA_W=8 (R=4, CW_W=13): i_data=0xA5, mask=0 → o_data=0xA5 two cycles later, all flags 0, o_err_pos=0.
- 0xA5, mask=13'h0008 (position 3) → o_data=0xA5, o_single_err=1, o_err_pos=3, o_cnt_corr=1.
- 0xA5, mask=13'h0028 (positions 3,5) → o_double_err=1, o_cnt_uncorr=1, o_err_pos=6.
- 0x3C, mask=13'h0001 → o_data=0x3C, o_parity_err=1, o_err_pos=0.
- Backpressure: hold o_ready=0, offer 3 words back-to-back → i_ready low after 2 accepted. Release → outputs appear in order with no loss or duplication.
- CNT_W=2: 5 single-error words → o_cnt_corr saturates at 3. Assert i_cnt_clr on the same cycle as a handshake → counter reads 0 next cycle.
